// File: rtl/mc_pkg.sv
// Shared constants for the multi-cycle RV32I controller: opcodes, FSM state
// encoding, next-PC select codes and the opcode class used by the FSM.
package mc_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_TRAP = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        NPC_PLUS_4   = 2'd0,
        NPC_BRANCH   = 2'd1,
        NPC_JUMP     = 2'd2,
        NPC_JUMP_REG = 2'd3
    } npc_sel_e;

    typedef enum logic [2:0] {
        CL_ALU,
        CL_LOAD,
        CL_STORE,
        CL_BRANCH,
        CL_JAL,
        CL_JALR
    } op_class_e;

    function automatic logic is_mem_class(input op_class_e c);
        return (c == CL_LOAD) || (c == CL_STORE);
    endfunction

endpackage

// File: rtl/mc_opclass.sv
// Combinational opcode-to-class decode; anything outside the RV32I base
// opcode set is flagged illegal.
module mc_opclass
    import mc_pkg::*;
(
    input  logic [6:0] opcode,
    output op_class_e  op_class,
    output logic       illegal
);

    always_comb begin
        op_class = CL_ALU;
        illegal  = 1'b0;
        case (opcode)
            OP_R, OP_I, OP_LUI, OP_AUIPC: op_class = CL_ALU;
            OP_LOAD:                      op_class = CL_LOAD;
            OP_STORE:                     op_class = CL_STORE;
            OP_BRANCH:                    op_class = CL_BRANCH;
            OP_JAL:                       op_class = CL_JAL;
            OP_JALR:                      op_class = CL_JALR;
            default:                      illegal  = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle RV32I control FSM (IF/ID/EX/MEM/WB/TRAP) with memory wait timeout.
// Define MC_CONTROL_PERF_EN to add cycle_cnt / instret_cnt performance counters.
module mc_control
    import mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        branch_taken,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  npc_sel,
    output logic        we_rf,
    output logic [2:0]  state,
    output logic        trap
`ifdef MC_CONTROL_PERF_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
`endif
);

    localparam int WCW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_e         st;
    state_e         st_nxt;
    logic [WCW-1:0] wait_cnt;
    op_class_e      op_class;
    logic           illegal;
    logic           timeout;
    logic           instr_unused;

    // Only the opcode field steers control; the rest belongs to the datapath.
    assign instr_unused = ^instr[31:7];

    mc_opclass u_opclass (
        .opcode   (instr[6:0]),
        .op_class (op_class),
        .illegal  (illegal)
    );

    // mem_req is high exactly in IF and MEM, so it doubles as the access-phase flag.
    assign timeout = (MEM_TIMEOUT != 0) && mem_req && !mem_ready &&
                     (wait_cnt == WCW'(MEM_TIMEOUT));

    always_comb begin
        st_nxt = st;
        case (st)
            S_IF: begin
                if (mem_ready)    st_nxt = S_ID;
                else if (timeout) st_nxt = S_TRAP;
            end
            S_ID:  st_nxt = illegal ? S_TRAP : S_EX;
            S_EX: begin
                if (op_class == CL_BRANCH)   st_nxt = S_IF;
                else if (is_mem_class(op_class)) st_nxt = S_MEM;
                else                         st_nxt = S_WB;
            end
            S_MEM: begin
                if (mem_ready)    st_nxt = (op_class == CL_STORE) ? S_IF : S_WB;
                else if (timeout) st_nxt = S_TRAP;
            end
            S_WB:    st_nxt = S_IF;
            default: st_nxt = S_TRAP;
        endcase
    end

    // State plus the state-decoded outputs, all registered from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st           <= S_IF;
            wait_cnt     <= '0;
            mem_req      <= 1'b1;
            mem_addr_sel <= 1'b0;
            mem_we       <= 1'b0;
            trap         <= 1'b0;
        end else begin
            st           <= st_nxt;
            wait_cnt     <= (mem_req && !mem_ready && (st_nxt == st)) ? wait_cnt + 1'b1 : '0;
            mem_req      <= (st_nxt == S_IF) || (st_nxt == S_MEM);
            mem_addr_sel <= (st_nxt == S_MEM);
            mem_we       <= (st_nxt == S_MEM) && (op_class == CL_STORE);
            trap         <= (st_nxt == S_TRAP);
        end
    end

    // Strobes qualify on same-cycle handshakes; gating with rst_n lets a reset
    // abort an in-flight access without a final pc_we/we_rf.
    always_comb begin
        ir_we   = 1'b0;
        pc_we   = 1'b0;
        we_rf   = 1'b0;
        npc_sel = NPC_PLUS_4;
        if (rst_n) begin
            case (st)
                S_IF: ir_we = mem_ready;
                S_EX: begin
                    if (op_class == CL_BRANCH) begin
                        pc_we   = 1'b1;
                        npc_sel = branch_taken ? NPC_BRANCH : NPC_PLUS_4;
                    end
                end
                S_MEM: pc_we = mem_ready && (op_class == CL_STORE);
                S_WB: begin
                    pc_we = 1'b1;
                    we_rf = 1'b1;
                    case (op_class)
                        CL_JAL:  npc_sel = NPC_JUMP;
                        CL_JALR: npc_sel = NPC_JUMP_REG;
                        default: npc_sel = NPC_PLUS_4;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign state = st;

`ifdef MC_CONTROL_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else if (st != S_TRAP) begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (pc_we) instret_cnt <= instret_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: driver pushes expected output events,
// a negedge monitor pops and compares whenever the DUT shows one.
module tb_mc_control;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = 32'h0;
    logic        branch_taken = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, we_rf, trap;
    logic [1:0]  npc_sel;
    logic [2:0]  state;
`ifdef MC_CONTROL_PERF_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    mc_control #(.MEM_TIMEOUT(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr        (instr),
        .branch_taken (branch_taken),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .npc_sel      (npc_sel),
        .we_rf        (we_rf),
        .state        (state),
        .trap         (trap)
`ifdef MC_CONTROL_PERF_EN
        ,
        .cycle_cnt    (cycle_cnt),
        .instret_cnt  (instret_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [2:0] st;
        logic       ir, pc, rf;
        logic [1:0] npc;
        logic       req, asel, we, trp;
    } ev_t;

    typedef enum {K_ALU, K_LOAD, K_STORE, K_BR, K_JAL, K_JALR} kind_e;

    ev_t exp_q[$];
    int  total = 0;
    int  bad = 0;

    function automatic void expect_ev(input int c, input logic [2:0] s, input logic ir,
                                      input logic pc, input logic rf, input logic [1:0] npc,
                                      input logic req, input logic asel, input logic we,
                                      input logic trp);
        ev_t e;
        e.cyc = c; e.st = s; e.ir = ir; e.pc = pc; e.rf = rf; e.npc = npc;
        e.req = req; e.asel = asel; e.we = we; e.trp = trp;
        exp_q.push_back(e);
    endfunction

    // Monitor: an event is any strobe, a completed memory handshake, or trap rising.
    logic trap_d = 1'b0;
    always @(negedge clk) begin : mon
        ev_t  e;
        logic hit;
        logic ok;
        hit = ir_we | pc_we | we_rf | (mem_req & mem_ready) | (trap & ~trap_d);
        trap_d <= trap;
        if (hit) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL ev_unexpected: cyc=%0d st=%0d ir=%b pc=%b rf=%b npc=%0d req=%b asel=%b we=%b trap=%b, no event required",
                         cyc, state, ir_we, pc_we, we_rf, npc_sel, mem_req, mem_addr_sel, mem_we, trap);
            end else begin
                e = exp_q.pop_front();
                ok = (cyc == e.cyc) && (state == e.st) && (ir_we == e.ir) && (pc_we == e.pc) &&
                     (we_rf == e.rf) && (mem_req == e.req) && (mem_we == e.we) && (trap == e.trp) &&
                     (!e.pc || npc_sel == e.npc) && (!e.req || mem_addr_sel == e.asel);
                if (!ok) begin
                    bad++;
                    $display("FAIL ev: got cyc=%0d st=%0d ir=%b pc=%b rf=%b npc=%0d req=%b asel=%b we=%b trap=%b want cyc=%0d st=%0d ir=%b pc=%b rf=%b npc=%0d req=%b asel=%b we=%b trap=%b",
                             cyc, state, ir_we, pc_we, we_rf, npc_sel, mem_req, mem_addr_sel, mem_we, trap,
                             e.cyc, e.st, e.ir, e.pc, e.rf, e.npc, e.req, e.asel, e.we, e.trp);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        mem_ready = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rst_state", {29'd0, state}, 32'd0);
        chk("rst_trap", {31'd0, trap}, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd1);
        chk("rst_strobes", {28'd0, ir_we, pc_we, we_rf, mem_we}, 32'd0);
    endtask

    // One instruction from its IF cycle; if_w / mem_w are wait cycles before mem_ready.
    task automatic run_instr(input logic [31:0] ins, input kind_e k, input int if_w,
                             input int mem_w, input logic taken);
        instr = ins;
        for (int i = 0; i <= if_w; i++) begin
            mem_ready = (i == if_w);
            branch_taken = ~taken;
            if (i == if_w) expect_ev(cyc, 3'd0, 1, 0, 0, 2'd0, 1, 0, 0, 0);
            step();
        end
        mem_ready = 1'b1;
        step();
        branch_taken = taken;
        if (k == K_BR) begin
            expect_ev(cyc, 3'd2, 0, 1, 0, taken ? 2'd1 : 2'd0, 0, 0, 0, 0);
            step();
            return;
        end
        step();
        branch_taken = ~taken;
        if (k == K_LOAD || k == K_STORE) begin
            for (int i = 0; i <= mem_w; i++) begin
                mem_ready = (i == mem_w);
                if (i == mem_w)
                    expect_ev(cyc, 3'd3, 0, (k == K_STORE), 0, 2'd0, 1, 1, (k == K_STORE), 0);
                step();
            end
            if (k == K_STORE) return;
        end
        mem_ready = 1'b1;
        expect_ev(cyc, 3'd4, 0, 1, 1, (k == K_JAL) ? 2'd2 : (k == K_JALR) ? 2'd3 : 2'd0, 0, 0, 0, 0);
        step();
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        step();
        reset_dut();

        run_instr(32'h003100B3, K_ALU,   0, 0, 1'b0);  // add x1,x2,x3
        run_instr(32'h0000A083, K_LOAD,  2, 2, 1'b0);  // lw
        run_instr(32'h00208463, K_BR,    0, 0, 1'b1);  // beq taken
        run_instr(32'h00208463, K_BR,    0, 0, 1'b0);  // beq not taken
        run_instr(32'h0020A023, K_STORE, 0, 1, 1'b0);  // sw
        run_instr(32'h008000EF, K_JAL,   1, 0, 1'b0);  // jal
        run_instr(32'h000080E7, K_JALR,  0, 0, 1'b0);  // jalr
        run_instr(32'h123450B7, K_ALU,   0, 0, 1'b0);  // lui
        run_instr(32'h003100B3, K_ALU,   4, 0, 1'b0);  // ready in last allowed cycle

        // Fetch never completes: timeout after 4 wait cycles, then absorbing.
        instr = 32'h003100B3;
        c0 = cyc;
        expect_ev(c0 + 5, 3'd5, 0, 0, 0, 2'd0, 0, 0, 0, 1);
        mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) step();
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            branch_taken = ~branch_taken;
            step();
        end
        chk("trap_state", {29'd0, state}, 32'd5);
        chk("trap_flag", {31'd0, trap}, 32'd1);
        chk("trap_quiet", {27'd0, mem_req, ir_we, pc_we, we_rf, mem_we}, 32'd0);

        // Illegal opcode traps straight out of ID.
        reset_dut();
        instr = 32'h0000007F;
        c0 = cyc;
        expect_ev(c0, 3'd0, 1, 0, 0, 2'd0, 1, 0, 0, 0);
        expect_ev(c0 + 2, 3'd5, 0, 0, 0, 2'd0, 0, 0, 0, 1);
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("illegal_state", {29'd0, state}, 32'd5);

        // Reset during a stalled store MEM: abort with no pc_we.
        reset_dut();
        instr = 32'h0020A023;
        c0 = cyc;
        expect_ev(c0, 3'd0, 1, 0, 0, 2'd0, 1, 0, 0, 0);
        mem_ready = 1'b1;
        step();
        step();
        step();
        mem_ready = 1'b0;
        chk("sw_mem_state", {29'd0, state}, 32'd3);
        chk("sw_mem_we", {30'd0, mem_we, mem_addr_sel}, 32'd3);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("abort_state", {29'd0, state}, 32'd0);
        chk("abort_trap", {31'd0, trap}, 32'd0);
        run_instr(32'h003100B3, K_ALU, 0, 0, 1'b0);

        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255, maximum wait cycles per memory access before trap; 0 disables timeout.
REQ-002 SHALL have port clk  in  1  system clock, all logic on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset; one clock, synchronous, active-low.
REQ-004 SHALL have port instr  in  32  current instruction register contents; opcode = instr[6:0].
REQ-005 SHALL have port branch_taken  in  1  branch condition from datapath compare, valid in EX.
REQ-006 SHALL have port mem_ready  in  1  shared memory accepts/completes the access this cycle.
REQ-007 SHALL have port mem_req  out  1  memory access request, held until mem_ready.
REQ-008 SHALL have port mem_we  out  1  write qualifier for mem_req; only ever high together with mem_req.
REQ-009 SHALL have port mem_addr_sel  out  1  memory address select; 0 = PC (fetch), 1 = ALU result (data).
REQ-010 SHALL have port ir_we  out  1  instruction register load strobe.
REQ-011 SHALL have port pc_we  out  1  PC update strobe.
REQ-012 SHALL have port npc_sel  out  2  next-PC select: PLUS_4, BRANCH, JUMP, JUMP_REG.
REQ-013 SHALL have port we_rf  out  1  register file write strobe.
REQ-014 SHALL have port state  out  3  current FSM state code, for debug.
REQ-015 SHALL have port trap  out  1  sticky fault indicator.

Function
REQ-016 SHALL implement the FSM states IF, ID, EX, MEM, WB, and TRAP.
REQ-017 In IF, SHALL drive mem_req=1 and mem_addr_sel=0; on mem_ready, SHALL pulse ir_we for one cycle and go to ID.
REQ-018 In ID, SHALL spend one cycle, go to TRAP on an opcode outside RV32I (R, I, load, store, B, JAL, JALR, LUI, AUIPC), otherwise go to EX.
REQ-019 In EX for B-type, SHALL pulse pc_we with npc_sel=BRANCH if branch_taken, else PLUS_4, and go to IF.
REQ-020 In EX for load or store, SHALL go to MEM; for all other legal classes, SHALL go to WB.
REQ-021 In MEM, SHALL drive mem_req=1, mem_addr_sel=1, and mem_we=1 for stores only; on mem_ready, a store SHALL pulse pc_we (PLUS_4) and go to IF, and a load SHALL go to WB.
REQ-022 In WB, SHALL pulse we_rf and pc_we for one cycle with npc_sel JUMP (JAL), JUMP_REG (JALR), or PLUS_4 (others), then go to IF.
REQ-023 Latency with zero-wait memory SHALL be: branch 3 cycles; R/I/LUI/AUIPC/JAL/JALR/store 4 cycles; load 5 cycles.
REQ-024 ir_we, pc_we and we_rf SHALL never be high in the same cycle as one another, except pc_we with we_rf in WB.
REQ-025 The wait counter SHALL count cycles with mem_req=1 and mem_ready=0, and SHALL clear on each mem_ready or state change.
REQ-026 If the wait counter equals MEM_TIMEOUT (nonzero) while mem_ready=0, SHALL go to TRAP on the next edge.
REQ-027 mem_ready in the final allowed cycle SHALL take priority over the timeout.
REQ-028 TRAP SHALL be absorbing until reset, with trap=1 and all strobes and mem_req 0.
REQ-029 mem_ready while mem_req=0 SHALL be ignored.

Reset
REQ-030 On rst_n=0 at a clock edge, SHALL enter IF with the wait counter 0, trap=0, and ir_we, pc_we, we_rf, mem_we 0; mem_req SHALL assert in the first cycle after reset release.
REQ-031 Reset asserted mid-access, including mid-MEM store, SHALL abort the access with no further pc_we or we_rf.

Configuration
REQ-032 With MC_CONTROL_PERF_EN defined, SHALL add 32-bit outputs cycle_cnt (increments every non-reset cycle, wraps) and instret_cnt (increments on each pc_we, wraps), both reset to 0 and frozen in TRAP.
REQ-033 Without MC_CONTROL_PERF_EN, those ports and their counters SHALL be absent.

Structure
REQ-034 Package mc_pkg SHALL hold the opcode constants, the state encoding (IF=0, ID=1, EX=2, MEM=3, WB=4, TRAP=5), and the npc_sel codes (PLUS_4=0, BRANCH=1, JUMP=2, JUMP_REG=3).
REQ-035 Sub-module mc_opclass SHALL provide combinational opcode-to-class decode and the illegal-opcode flag.

Verification
REQ-036 add x1,x2,x3 (0x003100B3), mem_ready=1 -> states IF,ID,EX,WB; we_rf and pc_we (PLUS_4) in cycle 4; next mem_req in cycle 5.
REQ-037 lw (0x0000A083) with 2 wait cycles in both IF and MEM -> 9 cycles total, mem_addr_sel=1 and mem_we=0 in MEM, we_rf in the last cycle.
REQ-038 beq with branch_taken=1, then with branch_taken=0 -> 3 cycles each; npc_sel BRANCH, then PLUS_4; we_rf never asserted.
REQ-039 MEM_TIMEOUT=4 with mem_ready held 0 in IF -> trap=1 after cycle 5, then stuck; mem_ready arriving in cycle 5 instead -> normal ID.
REQ-040 opcode 0x7F -> TRAP after ID; rst_n low for one edge during a stalled sw MEM -> IF next cycle, no pc_we pulse, trap=0.
